// File: rtl/lsu.sv
// Load/store unit: one aligned 64-bit memory request per op, with load-data
// extraction and a valid/ready result handshake to writeback.
module lsu #(
    parameter int DATA_W = 64,
    parameter int OPT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPT_W-1:0]  in_opt,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);

    localparam logic [OPT_W-1:0] OP_LB  = OPT_W'(1);
    localparam logic [OPT_W-1:0] OP_LH  = OPT_W'(2);
    localparam logic [OPT_W-1:0] OP_LW  = OPT_W'(3);
    localparam logic [OPT_W-1:0] OP_LD  = OPT_W'(4);
    localparam logic [OPT_W-1:0] OP_LBU = OPT_W'(5);
    localparam logic [OPT_W-1:0] OP_LHU = OPT_W'(6);
    localparam logic [OPT_W-1:0] OP_LWU = OPT_W'(7);
    localparam logic [OPT_W-1:0] OP_SB  = OPT_W'(8);
    localparam logic [OPT_W-1:0] OP_SH  = OPT_W'(9);
    localparam logic [OPT_W-1:0] OP_SW  = OPT_W'(10);
    localparam logic [OPT_W-1:0] OP_SD  = OPT_W'(11);

    typedef enum logic [1:0] {IDLE, REQ, RSP, OUT} state_t;

    state_t            state, state_next;
    logic [OPT_W-1:0]  opt_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_misalign_q;

    // Access size as log2(bytes); only meaningful for memory ops.
    function automatic logic [1:0] size_of(input logic [OPT_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
            OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
            OP_LW, OP_LWU, OP_SW: size_of = 2'd2;
            default:              size_of = 2'd3;
        endcase
    endfunction

    function automatic logic is_mem(input logic [OPT_W-1:0] op);
        is_mem = (op >= OP_LB) && (op <= OP_SD);
    endfunction

    function automatic logic is_store(input logic [OPT_W-1:0] op);
        is_store = (op >= OP_SB) && (op <= OP_SD);
    endfunction

    function automatic logic misaligned(input logic [OPT_W-1:0] op, input logic [2:0] a);
        case (size_of(op))
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = (a[1:0] != 2'b00);
            default: misaligned = (a != 3'b000);
        endcase
        misaligned = misaligned && is_mem(op);
    endfunction

    logic accept;
    logic in_misalign;
    assign accept      = (state == IDLE) && in_valid;
    assign in_misalign = misaligned(in_opt, in_addr[2:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = (is_mem(in_opt) && !in_misalign) ? REQ : OUT;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = RSP;
            end
            RSP: begin
                if (mem_rsp_valid) state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pick the addressed lane, then extend to the op's width and signedness.
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_val;
    assign lane = mem_rsp_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_val = '0;
        case (opt_q)
            OP_LB:  load_val = {{(DATA_W-8){lane[7]}},   lane[7:0]};
            OP_LH:  load_val = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            OP_LW:  load_val = {{(DATA_W-32){lane[31]}}, lane[31:0]};
            OP_LBU: load_val = {{(DATA_W-8){1'b0}},      lane[7:0]};
            OP_LHU: load_val = {{(DATA_W-16){1'b0}},     lane[15:0]};
            OP_LWU: load_val = {{(DATA_W-32){1'b0}},     lane[31:0]};
            OP_LD:  load_val = lane;
            default: load_val = '0;
        endcase
    end

    // NOTE: non-blocking assignments keep every register update in this block ordered by the clock edge, not by statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            out_data_q     <= '0;
            out_misalign_q <= 1'b0;
        end else if (accept) begin
            opt_q          <= in_opt;
            addr_q         <= in_addr;
            wdata_q        <= in_wdata;
            out_data_q     <= in_addr;
            out_misalign_q <= in_misalign;
        end else if (state == RSP && mem_rsp_valid) begin
            out_data_q     <= is_store(opt_q) ? '0 : load_val;
        end
    end

    logic [7:0] mask_raw;
    always_comb begin
        case (size_of(opt_q))
            2'd0:    mask_raw = 8'h01 << addr_q[2:0];
            2'd1:    mask_raw = 8'h03 << addr_q[2:0];
            2'd2:    mask_raw = 8'h0F << addr_q[2:0];
            default: mask_raw = 8'hFF;
        endcase
    end

    assign mem_req_addr  = {addr_q[DATA_W-1:3], 3'b000};
    assign mem_req_wdata = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_req_wen   = mem_req_valid && is_store(opt_q);
    assign mem_req_wmask = mem_req_wen ? mask_raw : 8'h00;
    assign out_data      = out_data_q;
    assign out_misalign  = out_misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, randomized ops against a
// byte-level reference model, and a reset-during-response sequence.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opt;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_misalign;

    lsu #(.DATA_W(64), .OPT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opt(in_opt),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opt;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        exp_mem;
        logic        exp_wen;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic [63:0] exp_data;
        logic        exp_mis;
        int          req_dly;
        int          rsp_dly;
        int          out_dly;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] opt, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rdata,
                                input logic exp_mem, input logic exp_wen,
                                input logic [63:0] exp_wdata, input logic [7:0] exp_mask,
                                input logic [63:0] exp_data, input logic exp_mis,
                                input int req_dly, input int rsp_dly, input int out_dly);
        vec_t v;
        v.opt = opt; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.exp_mem = exp_mem; v.exp_wen = exp_wen; v.exp_wdata = exp_wdata;
        v.exp_mask = exp_mask; v.exp_data = exp_data; v.exp_mis = exp_mis;
        v.req_dly = req_dly; v.rsp_dly = rsp_dly; v.out_dly = out_dly;
        return v;
    endfunction

    // Reference model: bytes touched, signedness and alignment from the op table.
    function automatic int nbytes(input logic [3:0] opt);
        case (opt)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic vec_t model(input logic [3:0] opt, input logic [63:0] addr,
                                   input logic [63:0] wdata, input logic [63:0] rdata,
                                   input int rq, input int rs, input int od);
        vec_t v;
        int n = nbytes(opt);
        int a = int'(addr[2:0]);
        logic store = (opt >= 4'd8) && (opt <= 4'd11);
        logic sgn = (opt >= 4'd1) && (opt <= 4'd3);
        logic [63:0] val = '0;
        logic [15:0] m = '0;
        v.opt = opt; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.req_dly = rq; v.rsp_dly = rs; v.out_dly = od;
        v.exp_mis = (n > 0) && (a % n != 0);
        v.exp_mem = (n > 0) && !v.exp_mis;
        v.exp_wen = store;
        v.exp_wdata = wdata << (8 * a);
        for (int i = 0; i < n; i++) m[a + i] = 1'b1;
        v.exp_mask = store ? m[7:0] : 8'h00;
        if (!v.exp_mem) begin
            v.exp_data = addr;
        end else if (store) begin
            v.exp_data = '0;
        end else begin
            for (int i = 0; i < n; i++) val[8*i +: 8] = rdata[8*(a+i) +: 8];
            if (sgn && val[8*n-1]) for (int i = 8*n; i < 64; i++) val[i] = 1'b1;
            v.exp_data = val;
        end
        return v;
    endfunction

    task automatic check_req(input vec_t v);
        check("req_valid", mem_req_valid, 1'b1);
        check("req_addr", mem_req_addr, {v.addr[63:3], 3'b000});
        check("req_wen", mem_req_wen, v.exp_wen);
        check("req_wdata", mem_req_wdata, v.exp_wdata);
        check("req_wmask", mem_req_wmask, v.exp_mask);
        check("in_ready_busy", in_ready, 1'b0);
    endtask

    task automatic check_out(input vec_t v);
        check("out_valid", out_valid, 1'b1);
        check("out_data", out_data, v.exp_data);
        check("out_misalign", out_misalign, v.exp_mis);
        check("in_ready_busy", in_ready, 1'b0);
    endtask

    // Drive one op through the DUT; junk on in_* and stray responses while busy must be ignored.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_opt = v.opt; in_addr = v.addr; in_wdata = v.wdata;
        @(negedge clk);
        in_opt = 4'd4; in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom};
        if (v.exp_mem) begin
            check("out_valid_early", out_valid, 1'b0);
            check_req(v);
            for (int i = 0; i < v.req_dly; i++) begin
                mem_rsp_valid = 1'b1; mem_rsp_rdata = {$urandom, $urandom};
                @(negedge clk);
                check_req(v);
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("req_valid_drop", mem_req_valid, 1'b0);
            for (int i = 0; i < v.rsp_dly; i++) begin
                @(negedge clk);
                check("out_valid_wait", out_valid, 1'b0);
            end
            mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rsp_rdata = {$urandom, $urandom};
        end else begin
            check("no_mem_req", mem_req_valid, 1'b0);
        end
        check_out(v);
        for (int i = 0; i < v.out_dly; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_rdata = {$urandom, $urandom};
            @(negedge clk);
            check_out(v);
        end
        mem_rsp_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_done", out_valid, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opt = '0; in_addr = '0; in_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;

        vecs.push_back(mk(4'd0,  64'h1234, 64'h0, 64'h0, 0, 0, 64'h0, 8'h00, 64'h1234, 0, 0, 0, 0));
        vecs.push_back(mk(4'd1,  64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 64'h0, 8'h00,
                          64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0, 0));
        vecs.push_back(mk(4'd5,  64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 64'h0, 8'h00,
                          64'h80, 0, 0, 0, 0));
        vecs.push_back(mk(4'd9,  64'h2006, 64'hABCD, 64'h0, 1, 1, 64'hABCD_0000_0000_0000, 8'hC0,
                          64'h0, 0, 0, 1, 0));
        vecs.push_back(mk(4'd3,  64'h3002, 64'h0, 64'h0, 0, 0, 64'h0, 8'h00, 64'h3002, 1, 0, 0, 1));
        vecs.push_back(mk(4'd4,  64'h4000, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h0, 8'h00,
                          64'h0123_4567_89AB_CDEF, 0, 3, 0, 2));
        vecs.push_back(mk(4'd13, 64'hDEAD, 64'h0, 64'h0, 0, 0, 64'h0, 8'h00, 64'hDEAD, 0, 0, 0, 0));
        vecs.push_back(mk(4'd11, 64'h5008, 64'h1122_3344_5566_7788, 64'h0, 1, 1,
                          64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0, 1, 2, 1));
        vecs.push_back(mk(4'd2,  64'h6006, 64'h0, 64'h8001_0000_0000_0000, 1, 0, 64'h0, 8'h00,
                          64'hFFFF_FFFF_FFFF_8001, 0, 0, 0, 0));
        vecs.push_back(mk(4'd7,  64'h7004, 64'h0, 64'hF000_0000_1234_5678, 1, 0, 64'h0, 8'h00,
                          64'hF000_0000, 0, 0, 0, 0));
        vecs.push_back(mk(4'd11, 64'h5004, 64'h0, 64'h0, 0, 0, 64'h0, 8'h00, 64'h5004, 1, 0, 0, 0));
        vecs.push_back(mk(4'd8,  64'h9007, 64'hFFAB, 64'h0, 1, 1, 64'hAB00_0000_0000_0000, 8'h80,
                          64'h0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_wen", mem_req_wen, 1'b0);
        check("rst_req_addr", mem_req_addr, 64'h0);
        check("rst_req_wdata", mem_req_wdata, 64'h0);
        check("rst_req_wmask", mem_req_wmask, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_misalign", out_misalign, 1'b0);

        // A stray response while idle must not start anything.
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h5555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("idle_rsp_ignored", out_valid, 1'b0);

        foreach (vecs[i]) run_op(vecs[i]);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  opt   = 4'($urandom_range(0, 15));
            logic [63:0] addr  = {$urandom, $urandom};
            int          n     = nbytes(opt);
            if ($urandom_range(0, 2) != 0 && n > 0) addr[2:0] = 3'(addr[2:0] & ~(n - 1));
            run_op(model(opt, addr, {$urandom, $urandom}, {$urandom, $urandom},
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
        end

        // Reset while waiting for a response; the late response must be dropped.
        @(negedge clk);
        in_valid = 1'b1; in_opt = 4'd4; in_addr = 64'h8000; in_wdata = '0;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstmid_req", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstmid_in_rsp", mem_req_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hCAFE;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid_out_valid", out_valid, 1'b0);
            check("rstmid_in_ready", in_ready, 1'b1);
            check("rstmid_req_valid", mem_req_valid, 1'b0);
            @(negedge clk);
        end

        // The unit still works after the aborted op.
        run_op(model(4'd6, 64'hA00A, 64'h0, 64'h0000_0000_F00D_0000, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
